// File: rtl/adapter_fifo_sched_if.sv
// Handshake bundle for adapter_fifo_sched: two requesters, the attached FIFO port and the
// burst output stream. The slave modport is the adapter's view; master is the environment's.
interface adapter_fifo_sched_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  logic                  fifo_wr;
  logic [DATA_WIDTH-1:0] fifo_w_data;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_r_data;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sof;
  logic                  out_eof;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  fifo_r_data, fifo_full, fifo_empty, out_ready,
    output req0_ready, req1_ready, fifo_wr, fifo_w_data, fifo_rd,
    output out_valid, out_data, out_sof, out_eof
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output fifo_r_data, fifo_full, fifo_empty, out_ready,
    input  req0_ready, req1_ready, fifo_wr, fifo_w_data, fifo_rd,
    input  out_valid, out_data, out_sof, out_eof
  );
endinterface

// File: rtl/adapter_fifo_sched.sv
// Round-robin write arbiter into an external FWFT FIFO plus a burst read scheduler.
// Define ADAPTER_SCHED_HWM_EN to add the level_hwm high-water-mark output.
module adapter_fifo_sched #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sched_en,
  output logic [ADDR_WIDTH:0] level,
`ifdef ADAPTER_SCHED_HWM_EN
  output logic [ADDR_WIDTH:0] level_hwm,
`endif
  adapter_fifo_sched_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DepthC    = CW'(DEPTH);
  localparam logic [CW-1:0] BurstC    = CW'(BURST_LEN);
  localparam logic [CW-1:0] LastBeatC = CW'(BURST_LEN - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] level_q, level_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          last_q, last_d;  // 1: req1 was granted most recently
  logic          can_wr, grant1, wr, rd, valid;

  // Write arbiter: combinational grant, the requester not granted last wins a contest.
  always_comb begin
    can_wr = (level_q < DepthC) && !bus.fifo_full;
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);
    bus.req0_ready  = can_wr && bus.req0_valid && !grant1;
    bus.req1_ready  = can_wr && grant1;
    wr              = bus.req0_ready || bus.req1_ready;
    bus.fifo_wr     = wr;
    bus.fifo_w_data = grant1 ? bus.req1_data : bus.req0_data;
    last_d          = wr ? grant1 : last_q;
  end

  // Output stream; the empty/level guards keep the FIFO read pointer safe even if the
  // external FIFO and the local count ever disagree.
  always_comb begin
    valid         = (state_q == StBurst) && !bus.fifo_empty && (level_q != '0);
    rd            = valid && bus.out_ready;
    bus.out_valid = valid;
    bus.out_data  = bus.fifo_r_data;
    bus.fifo_rd   = rd;
    bus.out_sof   = valid && (beat_q == '0);
    bus.out_eof   = valid && (beat_q == LastBeatC);
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (sched_en && (level_q >= BurstC)) begin
          state_d = StBurst;
          beat_d  = '0;
        end
      end
      StBurst: begin
        if (rd) begin
          if (beat_q == LastBeatC) begin
            state_d = StIdle;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    unique case ({wr, rd})
      2'b10:   level_d = level_q + CW'(1);
      2'b01:   level_d = level_q - CW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      level_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      level_q <= level_d;
      last_q  <= last_d;
    end
  end

  assign level = level_q;

`ifdef ADAPTER_SCHED_HWM_EN
  logic [CW-1:0] hwm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (level_q > hwm_q) begin
      hwm_q <= level_q;
    end
  end

  assign level_hwm = hwm_q;
`endif
endmodule
